// File: rtl/mips_mem_arbiter.sv
// Two-port arbiter sharing one synchronous memory between the MIPS core (port 0) and the loader (port 1).
// Build option MEM_ARB_RR_EN: round-robin on contention; when undefined, port 0 has fixed priority.
module mips_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              owner_r;
  logic              last_r;
  logic              locked_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;

  logic arb_s;
  logic lock_eff_s;
  logic elig0_s;
  logic elig1_s;
  logic grant_s;
  logic win_s;

  // Eligibility and winner selection for the current arbitration cycle
  always_comb begin
    arb_s      = 1'b0;
    lock_eff_s = 1'b0;
    elig0_s    = 1'b0;
    elig1_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        arb_s      = 1'b1;
        lock_eff_s = locked_r & lock1;
        elig0_s    = req0 & ~lock_eff_s;
        elig1_s    = req1;
      end
      ST_RESP: begin
        // The port being acked is excluded; its req is still the one just served.
        arb_s      = 1'b1;
        lock_eff_s = owner_r & lock1;
        elig0_s    = req0 & owner_r & ~lock_eff_s;
        elig1_s    = req1 & ~owner_r;
      end
      default: begin
        arb_s      = 1'b0;
        lock_eff_s = 1'b0;
        elig0_s    = 1'b0;
        elig1_s    = 1'b0;
      end
    endcase

    grant_s = elig0_s | elig1_s;
    if (elig0_s && elig1_s) begin
`ifdef MEM_ARB_RR_EN
      win_s = ~last_r;
`else
      // last is still tracked for observability but carries no weight here
      win_s = last_r & 1'b0;
`endif
    end else begin
      win_s = elig1_s;
    end
  end

  // Next-state sequencing IDLE -> ISSUE -> RESP
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (grant_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, ownership, last-served and lock tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      owner_r  <= 1'b0;
      last_r   <= 1'b1;
      locked_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (arb_s) begin
        locked_r <= lock_eff_s;
      end else begin
        locked_r <= locked_r;
      end
      if (state_r == ST_RESP) begin
        last_r <= owner_r;
      end else begin
        last_r <= last_r;
      end
      if (arb_s && grant_s) begin
        owner_r <= win_s;
      end else begin
        owner_r <= owner_r;
      end
    end
  end

  // Capture of the winning request, held until the next grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r  <= '0;
      wdata_r <= '0;
      we_r    <= 1'b0;
    end else if (arb_s && grant_s) begin
      addr_r  <= win_s ? addr1  : addr0;
      wdata_r <= win_s ? wdata1 : wdata0;
      we_r    <= win_s ? we1    : we0;
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      we_r    <= we_r;
    end
  end

  assign mem_en    = (state_r == ST_ISSUE);
  assign mem_we    = (state_r == ST_ISSUE) & we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign ack0      = (state_r == ST_RESP) & ~owner_r;
  assign ack1      = (state_r == ST_RESP) & owner_r;
  assign rdata     = mem_rdata;
  assign busy      = (state_r != ST_IDLE);

endmodule
